// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and master multiplexer for a four-master shared bus.
// A watchdog forces a ready and pulses an interrupt when a slave access hangs.
module bus_arbiter_rr #(
  parameter int unsigned NUM_MST = 4,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MST-1:0]          m_req_,
  input  logic [NUM_MST*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MST-1:0]          m_as_,
  input  logic [NUM_MST-1:0]          m_rw,
  input  logic [NUM_MST*DATA_W-1:0]   m_wr_data,
  output logic [NUM_MST-1:0]          m_grnt_,
  output logic [DATA_W-1:0]           m_rd_data,
  output logic                        m_rdy_,
  output logic [ADDR_W-1:0]           s_addr,
  output logic                        s_as_,
  output logic                        s_rw,
  output logic [DATA_W-1:0]           s_wr_data,
  input  logic [DATA_W-1:0]           s_rd_data,
  input  logic                        s_rdy_,
  output logic                        timeout_irq,
  output logic [1:0]                  timeout_mst
);

  localparam int unsigned WDT_W = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  logic               state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q,  last_d;
  logic [WDT_W-1:0]   wdt_q,   wdt_d;
  logic [NUM_MST-1:0] grnt_q,  grnt_d;
  logic               irq_q,   irq_d;
  logic [1:0]         tmst_q,  tmst_d;
  logic [NUM_MST-1:0] req;

  // First requester found scanning base+1, base+2, ... (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [NUM_MST-1:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = 2'(base + 2'(i));
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign req = ~m_req_;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grnt_d    = grnt_q;
    wdt_d     = '0;
    irq_d     = 1'b0;
    tmst_d    = tmst_q;
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    m_rdy_    = 1'b1;
    m_rd_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = rr_pick(last_q, req);
          state_d = ST_OWN;
          grnt_d  = ~(NUM_MST'(1) << owner_d);
        end
      end
      default: begin
        s_addr    = m_addr[owner_q*ADDR_W +: ADDR_W];
        s_as_     = m_as_[owner_q];
        s_rw      = m_rw[owner_q];
        s_wr_data = m_wr_data[owner_q*DATA_W +: DATA_W];
        m_rdy_    = s_rdy_;
        m_rd_data = s_rd_data;

        // Hung access: a real ready in the same cycle wins over expiry.
        if (!m_as_[owner_q] && s_rdy_) begin
          if (wdt_q == WDT_W'(TIMEOUT)) begin
            m_rdy_    = 1'b0;
            m_rd_data = '0;
            irq_d     = 1'b1;
            tmst_d    = owner_q;
          end else begin
            wdt_d = wdt_q + WDT_W'(1);
          end
        end

        // Release: hand over without a gap, or fall back to idle.
        if (m_req_[owner_q]) begin
          last_d = owner_q;
          if (|req) begin
            owner_d = rr_pick(owner_q, req);
            grnt_d  = ~(NUM_MST'(1) << owner_d);
          end else begin
            state_d = ST_IDLE;
            grnt_d  = '1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      wdt_q   <= '0;
      grnt_q  <= '1;
      irq_q   <= 1'b0;
      tmst_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdt_q   <= wdt_d;
      grnt_q  <= grnt_d;
      irq_q   <= irq_d;
      tmst_q  <= tmst_d;
    end
  end

  assign m_grnt_     = grnt_q;
  assign timeout_irq = irq_q;
  assign timeout_mst = tmst_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: reset, rotation, handover, watchdog, async reset.
module tb_bus_arbiter_rr;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           m_req_;
  logic [4*ADDR_W-1:0]  m_addr;
  logic [3:0]           m_as_;
  logic [3:0]           m_rw;
  logic [4*DATA_W-1:0]  m_wr_data;
  logic [3:0]           m_grnt_;
  logic [DATA_W-1:0]    m_rd_data;
  logic                 m_rdy_;
  logic [ADDR_W-1:0]    s_addr;
  logic                 s_as_;
  logic                 s_rw;
  logic [DATA_W-1:0]    s_wr_data;
  logic [DATA_W-1:0]    s_rd_data;
  logic                 s_rdy_;
  logic                 timeout_irq;
  logic [1:0]           timeout_mst;

  int n_checks = 0;
  int n_fails  = 0;

  bus_arbiter_rr #(.NUM_MST(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_),
    .m_rw(m_rw), .m_wr_data(m_wr_data), .m_grnt_(m_grnt_), .m_rd_data(m_rd_data),
    .m_rdy_(m_rdy_), .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw),
    .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
    .timeout_irq(timeout_irq), .timeout_mst(timeout_mst)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] grant_of(input int k);
    logic [3:0] g;
    g = 4'b1111;
    g[k] = 1'b0;
    return g;
  endfunction

  initial begin
    reset     = 1'b1;
    m_req_    = 4'b1111;
    m_as_     = 4'b1111;
    m_rw      = 4'b1111;
    s_rdy_    = 1'b1;
    s_rd_data = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      m_addr[i*ADDR_W +: ADDR_W]    = 30'h100 + 30'(i);
      m_wr_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i);
    end

    // Reset values
    #12;
    chk("rst_grnt", 64'(m_grnt_), 64'hF);
    chk("rst_s_as", 64'(s_as_), 64'h1);
    chk("rst_s_rw", 64'(s_rw), 64'h1);
    chk("rst_s_addr", 64'(s_addr), 64'h0);
    chk("rst_s_wdata", 64'(s_wr_data), 64'h0);
    chk("rst_m_rdy", 64'(m_rdy_), 64'h1);
    chk("rst_m_rdata", 64'(m_rd_data), 64'h0);
    chk("rst_irq", 64'(timeout_irq), 64'h0);
    chk("rst_tmst", 64'(timeout_mst), 64'h0);

    // Release reset with master 0 requesting: one cycle of latency
    @(negedge clk);
    reset  = 1'b0;
    m_req_ = 4'b1110;
    #1;
    chk("lat_grnt_before", 64'(m_grnt_), 64'hF);
    tick();
    chk("lat_grnt_after", 64'(m_grnt_), 64'hE);
    m_as_ = 4'b1110;
    #1;
    chk("own0_s_addr", 64'(s_addr), 64'h100);
    chk("own0_s_as", 64'(s_as_), 64'h0);
    m_as_ = 4'b1111;

    // All requesting, each owner holds two cycles: strict rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      m_req_ = 4'b0000;
      #1;
      chk($sformatf("rot%0d_c1", i), 64'(m_grnt_), 64'(grant_of(i % 4)));
      tick();
      chk($sformatf("rot%0d_c2", i), 64'(m_grnt_), 64'(grant_of(i % 4)));
      m_req_ = 4'b0000;
      m_req_[i % 4] = 1'b1;
      tick();
    end
    chk("rot_next1", 64'(m_grnt_), 64'hD);
    m_req_ = 4'b1111;
    tick();
    chk("rot_idle", 64'(m_grnt_), 64'hF);

    // Master 2 owns; releases as master 1 requests -> direct handover
    m_req_ = 4'b1011;
    tick();
    chk("ho_own2", 64'(m_grnt_), 64'hB);
    m_req_ = 4'b1101;
    tick();
    chk("ho_to1", 64'(m_grnt_), 64'hD);
    m_req_ = 4'b1111;
    tick();
    chk("ho_idle", 64'(m_grnt_), 64'hF);

    // Master 3 owns and reads from a slave that never responds
    m_req_ = 4'b0111;
    tick();
    chk("wd_own3", 64'(m_grnt_), 64'h7);
    m_as_ = 4'b0111;
    m_rw  = 4'b1000;
    #1;
    chk("wd_s_as", 64'(s_as_), 64'h0);
    chk("wd_s_rw", 64'(s_rw), 64'h1);
    chk("wd_s_addr", 64'(s_addr), 64'h103);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("wd_rdy_c%0d", c), 64'(m_rdy_), (c == 5) ? 64'h0 : 64'h1);
      if (c == 5) chk("wd_rdata_forced", 64'(m_rd_data), 64'h0);
      chk($sformatf("wd_irq_c%0d", c), 64'(timeout_irq), 64'h0);
      tick();
    end
    chk("wd_irq_pulse", 64'(timeout_irq), 64'h1);
    chk("wd_tmst", 64'(timeout_mst), 64'h3);
    chk("wd_grant_kept", 64'(m_grnt_), 64'h7);
    tick();
    chk("wd_irq_clear", 64'(timeout_irq), 64'h0);
    chk("wd_tmst_hold", 64'(timeout_mst), 64'h3);

    // Real ready arrives in the expiry cycle: passes data, no interrupt
    m_as_ = 4'b1111;
    tick();
    m_as_ = 4'b0111;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("rr_rdy_c%0d", c), 64'(m_rdy_), 64'h1);
      tick();
    end
    s_rdy_ = 1'b0;
    #1;
    chk("rr_rdy", 64'(m_rdy_), 64'h0);
    chk("rr_rdata", 64'(m_rd_data), 64'hDEADBEEF);
    tick();
    chk("rr_no_irq", 64'(timeout_irq), 64'h0);
    s_rdy_ = 1'b1;
    m_as_  = 4'b1111;

    // Asynchronous reset in the middle of a master-3 write
    m_rw  = 4'b0111;
    m_as_ = 4'b0111;
    #1;
    chk("ar_s_as_pre", 64'(s_as_), 64'h0);
    chk("ar_s_rw_pre", 64'(s_rw), 64'h0);
    chk("ar_s_wdata_pre", 64'(s_wr_data), 64'hA0000003);
    reset = 1'b1;
    #1;
    chk("ar_s_as", 64'(s_as_), 64'h1);
    chk("ar_grnt", 64'(m_grnt_), 64'hF);
    chk("ar_s_addr", 64'(s_addr), 64'h0);
    chk("ar_tmst", 64'(timeout_mst), 64'h0);
    @(negedge clk);
    reset  = 1'b0;
    m_as_  = 4'b1111;
    m_req_ = 4'b0000;
    tick();
    chk("ar_first_grant", 64'(m_grnt_), 64'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Shared-bus arbiter and master multiplexer sitting directly downstream of the CPU bus interfaces (IF-stage and MEM-stage masters) plus two further masters.
- Grants the bus to one master at a time with round-robin fairness.
- Steers the owner's address, strobe, read/write and write data to the slave side, and broadcasts read data and ready back to the masters.
- A watchdog converts a hung slave access into a forced ready plus an interrupt pulse, so a stalled bus never deadlocks the pipeline.

Parameters:
- NUM_MST, 4, number of masters (fixed at 4; owner index is 2 bits).
- ADDR_W, 30, word address width (matches WordAddrBus).
- DATA_W, 32, data width (matches WordDataBus).
- TIMEOUT, 255, wait cycles before a forced completion; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- m_req_  in  4  per-master bus request, active-low.
- m_addr  in  4*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_as_  in  4  per-master address strobe, active-low.
- m_rw  in  4  per-master read/write; 1 = read, 0 = write.
- m_wr_data  in  4*DATA_W  per-master write data; master i occupies bits [i*DATA_W +: DATA_W].
- m_grnt_  out  4  per-master grant, active-low, registered, one-hot-low or all-high.
- m_rd_data  out  DATA_W  read data broadcast to all masters.
- m_rdy_  out  1  ready broadcast to all masters, active-low.
- s_addr  out  ADDR_W  slave-side address.
- s_as_  out  1  slave-side address strobe, active-low.
- s_rw  out  1  slave-side read/write.
- s_wr_data  out  DATA_W  slave-side write data.
- s_rd_data  in  DATA_W  slave read data.
- s_rdy_  in  1  slave ready, active-low.
- timeout_irq  out  1  one-cycle pulse on watchdog expiry.
- timeout_mst  out  2  index of the master that timed out; holds until the next expiry.

Behaviour:
- Reset values:
  - state = IDLE, owner = 0, last = 3, wdt = 0.
  - m_grnt_ = 4'b1111; timeout_irq = 0; timeout_mst = 0.
  - Slave side idle: s_as_ = 1, s_rw = 1, s_addr = 0, s_wr_data = 0.
  - m_rdy_ = 1, m_rd_data = 0.
- State machine, two states:
  - IDLE: if any m_req_ bit is 0, pick the first requester scanning last+1, last+2, ... (mod 4). Next cycle: owner = pick, state = OWN, m_grnt_[pick] = 0. Otherwise stay in IDLE.
  - OWN: while m_req_[owner] = 0, hold the grant; there is no preemption.
  - OWN, when m_req_[owner] = 1: set last = owner. If another master is requesting, the next cycle grants the round-robin winner scanning from owner+1 (zero-gap handover). Otherwise the next cycle drops to IDLE with all grants high.
  - Request-to-grant latency is exactly 1 cycle from IDLE.
- Multiplexing, combinational from owner:
  - In OWN, the s_* outputs equal the owner's m_* inputs.
  - In IDLE, the s_* outputs take their idle values.
  - Non-owner strobes are ignored entirely.
- Return path:
  - m_rd_data = s_rd_data, m_rdy_ = s_rdy_ in OWN; idle values in IDLE.
  - Masters qualify the return path with their own grant.
- Watchdog (wdt, 8 bits):
  - In OWN, with s_as_ = 0 and s_rdy_ = 1, wdt increments.
  - Otherwise wdt is cleared.
  - When wdt == TIMEOUT in that condition, for that cycle:
    - m_rdy_ is forced to 0 and m_rd_data to 0;
    - timeout_irq = 1 next cycle (registered);
    - timeout_mst = owner;
    - wdt is cleared.
  - The grant is not revoked; the master finishes normally.
- Simultaneous events:
  - A real s_rdy_ = 0 in the expiry cycle takes priority: no irq, and real data is passed.
  - Owner releasing in the same cycle another master requests: handover as above.
  - All four masters requesting: the service order rotates strictly.
- Asynchronous reset mid-transfer forces the reset values immediately, independent of clk.

Test Plan:
- Reset released, m_req_ = 4'b1110 -> m_grnt_ = 4'b1111 for 1 cycle, then 4'b1110; s_addr tracks m_addr[0].
- m_req_ = 4'b0000 held, each master releasing after 2 cycles of ownership -> grants in order 0,1,2,3,0 with no idle cycle between owners.
- Master 2 owns, master 1 requests and master 2 releases in the same cycle -> next cycle m_grnt_ = 4'b1101; state never visits IDLE.
- Master 3 owns, m_as_[3] = 0, m_rw[3] = 1, s_rdy_ held 1, TIMEOUT = 4 -> m_rdy_ = 0 and m_rd_data = 0 in the 5th strobe cycle; timeout_irq pulses next cycle; timeout_mst = 2'd3.
- s_rdy_ goes 0 in the same cycle wdt reaches TIMEOUT -> m_rd_data = s_rd_data (e.g. 32'hDEADBEEF); timeout_irq stays 0.
- Assert reset during an OWN write, with s_as_ = 0 -> s_as_ = 1 and m_grnt_ = 4'b1111 before the next clk edge; first grant after release goes to master 0.
